// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - return-stack port bundle between pc_gen and the hardware return stack
//
// Signals:
//   stk_ctl  [1:0]  stack command (NOP / PSH / POP), driven by pc_gen
//   stk_din  [10:0] push data (return address), driven by pc_gen
//   stk_dout [10:0] top-of-stack, driven by the return stack
//   stk_ovf         sticky push-overflow flag, driven by pc_gen
//   stk_unf         sticky pop-underflow flag, driven by pc_gen
// Modports: master = pc_gen side, slave = return-stack side.
interface pc_gen_if;
  logic [1:0]  stk_ctl;
  logic [10:0] stk_din;
  logic [10:0] stk_dout;
  logic        stk_ovf;
  logic        stk_unf;

  modport master (
    output stk_ctl,
    output stk_din,
    output stk_ovf,
    output stk_unf,
    input  stk_dout
  );

  modport slave (
    input  stk_ctl,
    input  stk_din,
    input  stk_ovf,
    input  stk_unf,
    output stk_dout
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generation stage with return-stack control
//
// Holds the 11-bit fetch address and computes the next PC for INC, SKIP,
// GOTO, CALL, RETLW and PCL-write flows. Drives push/pop of the 4-entry
// return stack and a registered one-cycle squash (flush) for decode.
//
// Optional build macro: PC_STK_CHK_EN adds a stack depth counter with sticky
// overflow/underflow flags; without it stk_ovf/stk_unf are tied to 0.
//
// Ports:
//   clk            clock, all state on posedge
//   rst_n          synchronous active-low reset
//   stall          freeze pc, flush, depth and flags; no stack command
//   pc_op   [2:0]  0 INC, 1 SKIP, 2 GOTO, 3 CALL, 4 RETLW, 5 PCLWR, 6-7 INC
//   lit     [8:0]  instruction literal
//   pa      [1:0]  STATUS page bits
//   alu_res [7:0]  value written to PCL (with PCLWR)
//   pc      [10:0] current fetch address
//   flush          squash the instruction currently in decode
//   stk            return-stack bundle (pc_gen_if.master)
module pc_gen #(
  parameter logic [10:0] RESET_VEC = 11'h7FF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic [2:0]    pc_op,
  input  logic [8:0]    lit,
  input  logic [1:0]    pa,
  input  logic [7:0]    alu_res,
  output logic [10:0]   pc,
  output logic          flush,
  pc_gen_if.master      stk
);

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_SKIP  = 3'd1;
  localparam logic [2:0] OP_GOTO  = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RETLW = 3'd4;
  localparam logic [2:0] OP_PCLWR = 3'd5;

  localparam logic [1:0] STK_NOP = 2'b00;
  localparam logic [1:0] STK_PSH = 2'b01;
  localparam logic [1:0] STK_POP = 2'b10;

  logic [2:0]  eff_op;
  logic [10:0] pc_nxt;
  logic        flush_nxt;
  logic [1:0]  stk_cmd;

  // The instruction behind a redirect/skip is squashed: treat it as INC so it
  // neither redirects nor touches the stack.
  assign eff_op = flush ? OP_INC : pc_op;

  always_comb begin
    pc_nxt    = pc + 11'd1;
    flush_nxt = 1'b0;
    stk_cmd   = STK_NOP;
    case (eff_op)
      OP_SKIP: begin
        flush_nxt = 1'b1;
      end
      OP_GOTO: begin
        pc_nxt    = {pa, lit};
        flush_nxt = 1'b1;
      end
      OP_CALL: begin
        pc_nxt    = {pa, 1'b0, lit[7:0]};
        flush_nxt = 1'b1;
        stk_cmd   = STK_PSH;
      end
      OP_RETLW: begin
        // Top-of-stack is sampled now; the stack pops at the same edge.
        pc_nxt    = stk.stk_dout;
        flush_nxt = 1'b1;
        stk_cmd   = STK_POP;
      end
      OP_PCLWR: begin
        pc_nxt    = {pa, 1'b0, alu_res};
        flush_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // The instruction in execute sits at pc-1, so the return address is pc.
  assign stk.stk_din = pc;
  assign stk.stk_ctl = (rst_n && !stall) ? stk_cmd : STK_NOP;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= RESET_VEC;
      flush <= 1'b0;
    end else if (!stall) begin
      pc    <= pc_nxt;
      flush <= flush_nxt;
    end
  end

`ifdef PC_STK_CHK_EN
  logic [2:0] depth;
  logic       ovf_q;
  logic       unf_q;

  // stk_ctl is already NOP under stall/reset, so it alone qualifies updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth <= 3'd0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (stk.stk_ctl == STK_PSH) begin
      if (depth == 3'd4) ovf_q <= 1'b1;
      else               depth <= depth + 3'd1;
    end else if (stk.stk_ctl == STK_POP) begin
      if (depth == 3'd0) unf_q <= 1'b1;
      else               depth <= depth - 3'd1;
    end
  end

  assign stk.stk_ovf = ovf_q;
  assign stk.stk_unf = unf_q;
`else
  assign stk.stk_ovf = 1'b0;
  assign stk.stk_unf = 1'b0;
`endif

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generation stage for the clairisc core. Holds the 11-bit fetch address, computes the next PC for sequential, skip, GOTO, CALL, RETLW and PCL-write flows, and drives the push/pop interface of the 4-entry hardware return stack directly downstream. It also produces the one-cycle squash signal the fetch/decode pipeline uses to discard the instruction fetched behind a redirect or skip.

## Interface
- `RESET_VEC`, 11'h7FF: fetch address loaded on reset.
- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `stall` in 1: hold all state; no stack activity.
- `pc_op` in 3: 0 INC, 1 SKIP, 2 GOTO, 3 CALL, 4 RETLW, 5 PCLWR, 6–7 treated as INC.
- `lit` in 9: instruction literal k[8:0].
- `pa` in 2: STATUS page bits PA[1:0].
- `alu_res` in 8: result being written to PCL (valid with PCLWR).
- `stk_dout` in 11: top-of-stack from return stack.
- `pc` out 11: current fetch address to program memory.
- `flush` out 1: squash the instruction currently in decode.
- `stk_ctl` out 2: stack command using `STK_PSH`, `STK_POP` and `STK_NOP` from clairisc_def.h; `STK_NOP` is a new define whose value differs from both.
- `stk_din` out 11: push data, equal to `pc`.
- `stk_ovf` out 1: sticky overflow flag. Present only with the macro; otherwise tied 0.
- `stk_unf` out 1: sticky underflow flag. Present only with the macro; otherwise tied 0.

## Operation
- `pc` always holds the fetch address. The instruction in execute sits at `pc-1`, so the return address is `pc` itself.
- Effective op is `pc_op` when `flush`=0. When `flush`=1 the effective op is INC, because a squashed instruction has no effect.
- Next-PC rules, applied only when `rst_n`=1 and `stall`=0:
  - INC: `pc+1`. 11-bit wrap, so 7FF goes to 000.
  - SKIP: `pc+1`, and `flush` is set for the next cycle.
  - GOTO: `{pa, lit[8:0]}`, set flush.
  - CALL: `{pa, 1'b0, lit[7:0]}`, `stk_ctl`=PSH, `stk_din`=`pc`, set flush.
  - RETLW: `stk_dout`, `stk_ctl`=POP, set flush.
  - PCLWR: `{pa, 1'b0, alu_res}`, set flush.
- `flush` is registered. It is set by the rules above, otherwise cleared, and holds its value while `stall`=1.
- `stk_ctl` is combinational from the effective op. It is forced to NOP when `stall`=1 or `rst_n`=0, so at most one push or pop happens per non-stalled cycle.
- RETLW uses `stk_dout` as sampled in the same cycle the POP is issued. The stack updates at the same edge.

## Timing
- Reset values: `pc`=`RESET_VEC`, `flush`=0, `stk_ctl`=NOP, `stk_ovf`=0, `stk_unf`=0, depth=0.
- Redirect latency is one cycle: an op presented in cycle N gives the new `pc` and `flush`=1 in cycle N+1.
- Stall: `pc`, `flush`, depth and flags are all frozen. Release resumes exactly where the stage stopped.
- Reset asserted mid-operation (including during stall or flush) takes priority over everything. No stack command is issued in that cycle.
- Back-to-back redirects: the second op is ignored if it arrives while `flush`=1. Otherwise it takes effect normally.

## Configuration
- `PC_STK_CHK_EN` defined:
  - A 3-bit depth counter (0..4) tracks pushes and pops.
  - A PSH at depth 4 sets `stk_ovf`; depth stays 4.
  - A POP at depth 0 sets `stk_unf`; depth stays 0.
  - Both flags clear only on reset.
- Not defined: no counter is built, and `stk_ovf`/`stk_unf` are constant 0. Next-PC and stack behaviour are identical in both builds.

## Test plan
- Reset and sequential wrap: release `rst_n` with INC → `pc` 7FF, 000, 001; `flush` stays 0; `stk_ctl`=NOP throughout.
- CALL/RETLW: at `pc`=0x010, `pa`=2'b01, CALL with `lit`=0x1A5 → PSH with `stk_din`=0x010, next `pc`=0x2A5, `flush`=1 for one cycle. A later RETLW with `stk_dout`=0x010 → POP, `pc`=0x010, `flush`=1.
- GOTO/PCLWR: `pa`=2'b11, GOTO `lit`=0x1FF → `pc`=0x7FF. Then PCLWR with `alu_res`=0x3C → `pc`=0x63C. Each asserts `flush` exactly one cycle.
- Flush squash: a CALL presented in the cycle after a GOTO (while `flush`=1) → no PSH, `pc` increments, `flush` returns to 0.
- Stall: CALL presented with `stall`=1 for 3 cycles → `pc` unchanged, `stk_ctl`=NOP. On release the CALL executes once with a single PSH.
- With `PC_STK_CHK_EN`: 5 CALLs → `stk_ovf`=1 after the 5th. Reset, then one RETLW → `stk_unf`=1. Reset clears both flags.
